muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, multiply latency in cycles from acceptance to result (legal range 1..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port a  input  32  operand rs (dividend / multiplicand / MTHI-MTLO data).
REQ-005 SHALL have port b  input  32  operand rt (divisor / multiplier).
REQ-006 SHALL have port op  input  3  operation: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP).
REQ-007 SHALL have port start  input  1  request qualifier for op.
REQ-008 SHALL have port busy  output  1  operation in progress; the pipeline stalls MFHI/MFLO/new muldiv ops while high.
REQ-009 SHALL have port done  output  1  one-cycle pulse on the edge that writes the HI/LO result.
REQ-010 SHALL have port hi  output  32  HI register.
REQ-011 SHALL have port lo  output  32  LO register.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-013 SHALL accept a request only at a rising edge with start=1, busy=0, op in 001..110; a, b, op are captured at that edge and SHALL NOT be re-sampled afterwards.
REQ-014 SHALL ignore start while busy=1 (no queueing, no state change, HI/LO untouched).
REQ-015 MTHI/MTLO SHALL write a into hi/lo on the accepting edge, stay IDLE, not assert busy, and pulse done on the following cycle.
REQ-016 MULT SHALL produce the signed 64-bit product of a and b and MULTU the unsigned one; {hi,lo} = product.
REQ-017 A multiply SHALL hold busy for exactly MUL_CYCLES cycles after the accepting edge; hi/lo are written and busy falls on the MUL_CYCLES-th edge after acceptance.
REQ-018 DIV/DIVU SHALL use restoring shift-subtract on magnitudes, one quotient bit per cycle: 32 cycles in DIV, then 1 cycle in FIX for sign correction; total busy = 33 cycles.
REQ-019 DIVU SHALL give lo = a / b and hi = a % b, both unsigned.
REQ-020 DIV SHALL truncate toward zero: quotient negative iff the operand signs differ; remainder takes the sign of a; |hi| < |b|.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0.
REQ-022 Division by zero (b = 0, DIV or DIVU) SHALL still take 33 cycles and give lo = 0xFFFFFFFF, hi = a.
REQ-023 hi/lo SHALL hold their values throughout an operation and change only on the completing edge.
REQ-024 done SHALL be high for exactly one cycle, the cycle after the HI/LO write; a new request may be accepted in that same cycle.
REQ-025 hi/lo written by a completed operation SHALL remain until the next write or reset.

Reset
REQ-026 With rst_n=0 at a rising edge: state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, internal counter and partial results = 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no HI/LO write and no done pulse.
REQ-028 start SHALL be ignored on any edge where rst_n=0.

Verification
REQ-029 Reset, then MULT a=0xFFFFFFFF, b=2 -> busy 5 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse once; MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-030 DIV a=-7 (0xFFFFFFF9), b=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-031 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5 after 33 cycles.
REQ-032 Start a DIV, pulse start with MTHI a=0x1234 at cycle 10 -> MTHI ignored, final hi/lo are the division result.
REQ-033 Start a DIV, drive rst_n=0 for one edge at cycle 15 -> busy=0, hi=lo=0, no done pulse; a MTLO a=0xA5A5A5A5 issued next -> lo=0xA5A5A5A5, busy stays 0.
REQ-034 Randomized back-to-back ops issued on the cycle after each done pulse, checked against a 64-bit reference model, 10k ops, including 0, 0x80000000, 0xFFFFFFFF and 1 operands.

Source files
------------

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: multi-cycle MULT/MULTU, restoring DIV/DIVU,
// and MTHI/MTLO writes, with busy/done handshake toward the pipeline.
module muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] a_q, a_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        accept;
  logic        is_signed;
  logic [63:0] ext_a, ext_b, product;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, diff;
  logic        q_bit;
  logic [31:0] q_fix, r_fix;

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  assign accept = start && (state_q == S_IDLE)
               && (op != 3'b000) && (op != 3'b111);

  // operand conditioning for both multiply signedness and divide magnitudes
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign ext_a   = {{32{is_signed & a[31]}}, a};
  assign ext_b   = {{32{is_signed & b[31]}}, b};
  assign product = ext_a * ext_b;
  assign a_neg   = (op == OP_DIV) && a[31];
  assign b_neg   = (op == OP_DIV) && b[31];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;

  // one restoring step: trial-subtract divisor from shifted remainder
  assign rem_sh = {rem_q, quot_q[31]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign q_bit  = ~diff[32];
  assign q_fix  = qneg_q ? -quot_q : quot_q;
  assign r_fix  = rneg_q ? -rem_q : rem_q;

  // next-state and datapath selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              prod_d  = product;
              cnt_d   = MUL_LAST;
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              quot_d  = a_mag;
              rem_d   = '0;
              dvs_d   = b_mag;
              a_d     = a;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              dz_d    = (b == 32'd0);
              cnt_d   = 5'd31;
              state_d = S_DIV;
            end
            OP_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == 5'd0) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DIV: begin
        rem_d  = q_bit ? diff[31:0] : rem_sh[31:0];
        quot_d = {quot_q[30:0], q_bit};
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_FIX: begin
        if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule
